// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI chip-select / SCK timing generator.
package spi_pkg;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LO    = 3'd2,
        HI    = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

    // SPI mode encodings as {cpol, cpha}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Programmed counts of zero behave as one.
    function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/spi_phase_cnt.sv
// Loadable down-counter. o_tc marks the last cycle of a loaded interval:
// loading L gives exactly L cycles, the last of which has o_tc=1.
module spi_phase_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load on request, otherwise count down and rest at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/spi_cs_sck_timing.sv
// SPI master CS/SCK timing generator: one frame of N SCK cycles framed by
// programmable CS setup, hold and inter-frame gap, with sample/shift strobes.
module spi_cs_sck_timing
    import spi_pkg::*;
#(
    parameter int CS_NUM = 4,
    parameter int DIV_W  = 8,
    parameter int DLY_W  = 8,
    parameter int LEN_W  = 6,
    parameter int SEL_W  = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic [DIV_W-1:0]  i_half_div,
    input  logic [LEN_W-1:0]  i_sck_cycles,
    input  logic [DLY_W-1:0]  i_cs_setup,
    input  logic [DLY_W-1:0]  i_cs_hold,
    input  logic [DLY_W-1:0]  i_cs_idle,
    input  logic [SEL_W-1:0]  i_cs_sel,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [CS_NUM-1:0] o_cs_n,
    output logic              o_sck,
    output logic              o_sample_stb,
    output logic              o_shift_stb,
    output logic [2:0]        o_dbg_state
);

    // Handshake: i_start is taken only in a cycle where o_busy=0 (state IDLE);
    // o_done is a single-cycle pulse in the first IDLE cycle after a normal frame.

    spi_state_e        r_state;
    spi_state_e        w_next;

    // Frame configuration captured at start.
    logic              r_cpol;
    logic              r_cpha;
    logic [DIV_W-1:0]  r_half_div;
    logic [LEN_W-1:0]  r_sck_cycles;
    logic [DLY_W-1:0]  r_cs_hold;
    logic [DLY_W-1:0]  r_cs_idle;
    logic [SEL_W-1:0]  r_cs_sel;
    logic [LEN_W-1:0]  r_cyc;

    logic              w_accept;
    logic [DIV_W-1:0]  w_half;
    logic [LEN_W-1:0]  w_n;
    logic              w_last_cyc;
    logic              w_ph_load;
    logic              w_ph_tc;
    logic              w_dly_load;
    logic [DLY_W-1:0]  w_dly_val;
    logic              w_dly_tc;
    logic              w_lead;
    logic              w_trail;

    logic [1:0]        w_mode;
    logic              w_sample_on_lead;
    logic              w_shift_on_lead;
    logic              w_cpol_eff;
    logic [SEL_W-1:0]  w_sel_eff;
    logic              w_cs_on;
    logic [CS_NUM-1:0] w_cs_n_nxt;
    logic              w_sck_nxt;
    logic              w_sample_nxt;
    logic              w_shift_nxt;
    logic              w_done_nxt;

    assign w_accept   = (r_state == IDLE) && i_start;
    assign w_half     = DIV_W'(clamp_to_one(32'(r_half_div)));
    assign w_n        = LEN_W'(clamp_to_one(32'(r_sck_cycles)));
    assign w_last_cyc = (r_cyc == (w_n - LEN_W'(1)));

    // Half-period timer for LO/HI phases.
    spi_phase_cnt #(.W(DIV_W)) u_phase_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_ph_load),
        .i_val  (w_half),
        .o_tc   (w_ph_tc)
    );

    // Delay timer shared by SETUP, HOLD and GAP.
    spi_phase_cnt #(.W(DLY_W)) u_delay_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_dly_load),
        .i_val  (w_dly_val),
        .o_tc   (w_dly_tc)
    );

    // Next-state logic, timer loads and SCK edge detection; abort wins over all.
    always_comb begin
        w_next     = r_state;
        w_ph_load  = 1'b0;
        w_dly_load = 1'b0;
        w_dly_val  = '0;
        w_lead     = 1'b0;
        w_trail    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next     = SETUP;
                    w_dly_load = 1'b1;
                    w_dly_val  = DLY_W'(clamp_to_one(32'(i_cs_setup)));
                end
            end
            SETUP: begin
                if (w_dly_tc) begin
                    w_next    = LO;
                    w_ph_load = 1'b1;
                end
            end
            LO: begin
                if (w_ph_tc) begin
                    w_next    = HI;
                    w_ph_load = 1'b1;
                    w_lead    = 1'b1;
                end
            end
            HI: begin
                if (w_ph_tc) begin
                    w_trail = 1'b1;
                    if (w_last_cyc) begin
                        w_next     = HOLD;
                        w_dly_load = 1'b1;
                        w_dly_val  = DLY_W'(clamp_to_one(32'(r_cs_hold)));
                    end else begin
                        w_next    = LO;
                        w_ph_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_dly_tc) begin
                    if (r_cs_idle != '0) begin
                        w_next     = GAP;
                        w_dly_load = 1'b1;
                        w_dly_val  = r_cs_idle;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (w_dly_tc) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (i_abort && (r_state != IDLE)) begin
            w_next     = IDLE;
            w_ph_load  = 1'b0;
            w_dly_load = 1'b0;
            w_lead     = 1'b0;
            w_trail    = 1'b0;
        end
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        w_mode           = {r_cpol, r_cpha};
        w_sample_on_lead = (w_mode == MODE0) || (w_mode == MODE2);
        w_shift_on_lead  = (w_mode == MODE1) || (w_mode == MODE3);
        // Before a frame is latched the live inputs are the only valid source.
        w_cpol_eff = (r_state == IDLE) ? i_cpol : r_cpol;
        w_sel_eff  = (r_state == IDLE) ? i_cs_sel : r_cs_sel;
        w_cs_on    = (w_next == SETUP) || (w_next == LO) ||
                     (w_next == HI) || (w_next == HOLD);
        w_cs_n_nxt = '1;
        for (int i = 0; i < CS_NUM; i++) begin
            // Selects at or above CS_NUM match no line, so CS stays high.
            w_cs_n_nxt[i] = !(w_cs_on && (w_sel_eff == SEL_W'(i)));
        end
        w_sck_nxt    = (w_next == HI) ? ~w_cpol_eff : w_cpol_eff;
        w_sample_nxt = (w_sample_on_lead && w_lead) || (w_shift_on_lead && w_trail);
        w_shift_nxt  = (w_shift_on_lead && w_lead) ||
                       (w_sample_on_lead && w_trail && !w_last_cyc);
        w_done_nxt   = ((r_state == HOLD) || (r_state == GAP)) &&
                       (w_next == IDLE) && !i_abort;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Configuration capture at start and SCK cycle counting at each HI exit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_half_div   <= '0;
            r_sck_cycles <= '0;
            r_cs_hold    <= '0;
            r_cs_idle    <= '0;
            r_cs_sel     <= '0;
            r_cyc        <= '0;
        end else if (w_accept) begin
            r_cpol       <= i_cpol;
            r_cpha       <= i_cpha;
            r_half_div   <= i_half_div;
            r_sck_cycles <= i_sck_cycles;
            r_cs_hold    <= i_cs_hold;
            r_cs_idle    <= i_cs_idle;
            r_cs_sel     <= i_cs_sel;
            r_cyc        <= '0;
        end else if (w_trail) begin
            r_cyc <= r_cyc + LEN_W'(1);
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cs_n       <= '1;
            o_sck        <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_sample_stb <= 1'b0;
            o_shift_stb  <= 1'b0;
        end else begin
            o_cs_n       <= w_cs_n_nxt;
            o_sck        <= w_sck_nxt;
            o_busy       <= (w_next != IDLE);
            o_done       <= w_done_nxt;
            o_sample_stb <= w_sample_nxt;
            o_shift_stb  <= w_shift_nxt;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_cs_sck_timing.sv
// Bench for spi_cs_sck_timing: table of frame configurations with
// hand-computed timing, plus directed back-to-back, abort and reset sequences.
module tb_spi_cs_sck_timing;

  localparam int CS_NUM = 3;
  localparam int DIV_W  = 8;
  localparam int DLY_W  = 8;
  localparam int LEN_W  = 6;
  localparam int SEL_W  = 2;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cpol, i_cpha, i_start, i_abort;
  logic [DIV_W-1:0]  i_half_div;
  logic [LEN_W-1:0]  i_sck_cycles;
  logic [DLY_W-1:0]  i_cs_setup, i_cs_hold, i_cs_idle;
  logic [SEL_W-1:0]  i_cs_sel;
  logic              o_busy, o_done, o_sck, o_sample_stb, o_shift_stb;
  logic [CS_NUM-1:0] o_cs_n;
  logic [2:0]        o_dbg_state;

  typedef struct {
    logic             cpol;
    logic             cpha;
    logic [DIV_W-1:0] half_div;
    logic [LEN_W-1:0] sck_cycles;
    logic [DLY_W-1:0] setup;
    logic [DLY_W-1:0] hold;
    logic [DLY_W-1:0] idle;
    logic [SEL_W-1:0] sel;
    int               exp_done;
    int               exp_first;
    int               exp_nsmp;
    int               exp_nshf;
    logic [31:0]      exp_smp_mask;
    logic [31:0]      exp_shf_mask;
    logic [2:0]       exp_cs;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-frame measurements.
  int          m_done_t, m_first, m_nsmp, m_nshf, m_busy_gap, m_bad;
  logic [31:0] m_smp_mask, m_shf_mask;
  logic [2:0]  m_cs_t1, m_cs_done;
  logic        m_busy_done, m_sck_done;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  spi_cs_sck_timing #(
    .CS_NUM(CS_NUM), .DIV_W(DIV_W), .DLY_W(DLY_W), .LEN_W(LEN_W), .SEL_W(SEL_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cpol(i_cpol), .i_cpha(i_cpha),
    .i_half_div(i_half_div), .i_sck_cycles(i_sck_cycles),
    .i_cs_setup(i_cs_setup), .i_cs_hold(i_cs_hold), .i_cs_idle(i_cs_idle),
    .i_cs_sel(i_cs_sel), .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_cs_n(o_cs_n), .o_sck(o_sck),
    .o_sample_stb(o_sample_stb), .o_shift_stb(o_shift_stb),
    .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    i_cpol       = v.cpol;
    i_cpha       = v.cpha;
    i_half_div   = v.half_div;
    i_sck_cycles = v.sck_cycles;
    i_cs_setup   = v.setup;
    i_cs_hold    = v.hold;
    i_cs_idle    = v.idle;
    i_cs_sel     = v.sel;
  endtask

  // Start one frame (start cycle = t0) and trace it until done or budget.
  task automatic run_frame(input vec_t v);
    logic prev_sck, lead, trail;
    drive_cfg(v);
    m_done_t = -1; m_first = -1; m_nsmp = 0; m_nshf = 0; m_busy_gap = 0; m_bad = 0;
    m_smp_mask = '0; m_shf_mask = '0; m_cs_t1 = '0; m_cs_done = '0;
    m_busy_done = 1'b1; m_sck_done = ~v.cpol;
    @(posedge clk); #1; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    prev_sck = v.cpol;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (c == 1) m_cs_t1 = o_cs_n;
      lead  = (o_sck !== prev_sck) && (o_sck === ~v.cpol);
      trail = (o_sck !== prev_sck) && (o_sck === v.cpol);
      if (lead && m_first < 0) m_first = c;
      if (o_sample_stb) begin
        m_nsmp++;
        if (c < 32) m_smp_mask[c] = 1'b1;
        if (!(v.cpha ? trail : lead)) m_bad++;
      end
      if (o_shift_stb) begin
        m_nshf++;
        if (c < 32) m_shf_mask[c] = 1'b1;
        if (!(v.cpha ? lead : trail)) m_bad++;
      end
      if (o_done) begin
        m_done_t = c; m_busy_done = o_busy; m_sck_done = o_sck; m_cs_done = o_cs_n;
        break;
      end
      if (!o_busy) m_busy_gap++;
      prev_sck = o_sck;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    run_frame(v);
    check($sformatf("%s done_cycle", tag), m_done_t, v.exp_done);
    check($sformatf("%s first_edge", tag), m_first, v.exp_first);
    check($sformatf("%s n_sample", tag), m_nsmp, v.exp_nsmp);
    check($sformatf("%s n_shift", tag), m_nshf, v.exp_nshf);
    check($sformatf("%s sample_cycles", tag), m_smp_mask, v.exp_smp_mask);
    check($sformatf("%s shift_cycles", tag), m_shf_mask, v.exp_shf_mask);
    check($sformatf("%s cs_n_t1", tag), m_cs_t1, v.exp_cs);
    check($sformatf("%s cs_n_done", tag), m_cs_done, 32'h7);
    check($sformatf("%s busy_gaps", tag), m_busy_gap, 0);
    check($sformatf("%s busy_at_done", tag), m_busy_done, 0);
    check($sformatf("%s sck_at_done", tag), m_sck_done, v.cpol);
    check($sformatf("%s strobe_edge_align", tag), m_bad, 0);
  endtask

  int nd, d1, d2, cs_hi;

  initial begin
    //            cpol cpha half  n     setup hold  idle  sel   done first smp shf smp_mask    shf_mask   cs
    vecs[0] = '{1'b0, 1'b0, 8'd2, 6'd2, 8'd1, 8'd1, 8'd0, 2'd0, 11, 4, 2, 1, 32'h110,   32'h40,   3'b110};
    vecs[1] = '{1'b0, 1'b1, 8'd1, 6'd3, 8'd2, 8'd2, 8'd1, 2'd1, 12, 4, 3, 3, 32'h2A0,   32'h150,  3'b101};
    vecs[2] = '{1'b1, 1'b0, 8'd3, 6'd3, 8'd1, 8'd1, 8'd0, 2'd2, 21, 5, 3, 2, 32'h20820, 32'h4100, 3'b011};
    vecs[3] = '{1'b1, 1'b1, 8'd2, 6'd3, 8'd3, 8'd1, 8'd3, 2'd0, 20, 6, 3, 3, 32'h11100, 32'h4440, 3'b110};
    vecs[4] = '{1'b0, 1'b0, 8'd0, 6'd0, 8'd0, 8'd0, 8'd0, 2'd0,  5, 3, 1, 0, 32'h8,     32'h0,    3'b110};
    vecs[5] = '{1'b0, 1'b0, 8'd1, 6'd2, 8'd1, 8'd1, 8'd0, 2'd3,  7, 3, 2, 1, 32'h28,    32'h10,   3'b111};

    // Reset state, with cpol=1 so a reset sck of 0 is distinguishable.
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    drive_cfg(vecs[2]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cs_n", o_cs_n, 32'h7);
    check("reset sck", o_sck, 0);
    check("reset busy", o_busy, 0);
    check("reset done", o_done, 0);
    check("reset strobes", {o_sample_stb, o_shift_stb}, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames across modes and boundary values.
    for (int i = 0; i < 6; i++) check_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with start held high, idle=2, config disturbed mid-frame.
    i_cpol = 0; i_cpha = 0; i_half_div = 1; i_sck_cycles = 1;
    i_cs_setup = 1; i_cs_hold = 1; i_cs_idle = 2; i_cs_sel = 0;
    @(posedge clk); #1; i_start = 1'b1;
    nd = 0; d1 = -1; d2 = -1; cs_hi = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin i_half_div = 5; i_cs_sel = 1; i_cs_idle = 0; i_sck_cycles = 4; i_cpol = 1; end
      if (c == 5) begin i_half_div = 1; i_cs_sel = 0; i_cs_idle = 2; i_sck_cycles = 1; i_cpol = 0; end
      if (c == 8) i_start = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        check("b2b cs_n_t3", o_cs_n, 32'h6);
        check("b2b sck_t3", o_sck, 1);
      end
      if (o_done) begin
        if (d1 < 0) d1 = c; else d2 = c;
        nd++;
      end
      if (c <= 8 && o_cs_n[0]) cs_hi++;
    end
    check("b2b first_done", d1, 7);
    check("b2b second_done", d2, 14);
    check("b2b done_count", nd, 2);
    check("b2b cs_high_cycles", cs_hi, 3);

    // Abort in the last cycle of a HI phase (trailing edge would follow).
    i_cpol = 1; i_cpha = 0; i_half_div = 2; i_sck_cycles = 2;
    i_cs_setup = 1; i_cs_hold = 1; i_cs_idle = 0; i_cs_sel = 2;
    @(posedge clk); #1; i_start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) i_start = 1'b0;
      if (c == 5) i_abort = 1'b1;
      if (c == 6) i_abort = 1'b0;
      @(negedge clk);
      if (c == 5) begin
        check("abort pre sck", o_sck, 0);
        check("abort pre cs_n", o_cs_n, 32'h3);
      end
      if (c == 6) begin
        check("abort cs_n", o_cs_n, 32'h7);
        check("abort sck", o_sck, 1);
        check("abort busy", o_busy, 0);
        check("abort done", o_done, 0);
        check("abort strobes", {o_sample_stb, o_shift_stb}, 0);
      end
      if (c >= 6 && o_done) nd++;
    end
    check("abort no_done", nd, 0);

    // Reset pulse mid-frame, then a full frame afterwards.
    drive_cfg(vecs[2]);
    @(posedge clk); #1; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk);
    check("midrst cs_n", o_cs_n, 32'h7);
    check("midrst sck", o_sck, 0);
    check("midrst busy", o_busy, 0);
    check("midrst done", o_done, 0);
    check("midrst strobes", {o_sample_stb, o_shift_stb}, 0);
    check("midrst state", o_dbg_state, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    check_vec(vecs[2], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
